dpic_burst_ctrl: RTL and testbench

- Burst-to-single-beat sequencer placed directly upstream of the 1-cycle DPI-C RAM.
- Accepts one burst request (read or write, INCR or WRAP) from a cache/LSU on a valid/ready channel.
- Issues exactly one RAM access per accepted beat, returning read beats through a registered response buffer and write completion on a response channel.
- Guarantees each DPI-C access fires exactly once per beat; MMIO side effects are never duplicated under backpressure.

---
 rtl/dpic_burst_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_dpic_burst_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpic_burst_ctrl.sv
// Burst-to-single-beat sequencer in front of the 1-cycle DPI-C RAM.
// Each accepted beat issues exactly one RAM access; read data returns through a registered buffer.
module dpic_burst_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [LEN_WIDTH-1:0]    req_len,
  input  logic [1:0]              req_size,
  input  logic                    req_write,
  input  logic                    req_wrap,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic [DATA_WIDTH-1:0]   w_data,
  input  logic [DATA_WIDTH/8-1:0] w_strb,
  input  logic                    w_last,
  output logic                    r_valid,
  input  logic                    r_ready,
  output logic [DATA_WIDTH-1:0]   r_data,
  output logic                    r_last,
  output logic                    b_valid,
  input  logic                    b_ready,
  output logic                    b_err,
  output logic                    ram_en,
  output logic                    ram_re,
  output logic                    ram_we,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [1:0]              ram_size,
  output logic [DATA_WIDTH/8-1:0] ram_wmask,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  input  logic [DATA_WIDTH-1:0]   ram_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, BRESP = 2'd3} state_t;

  state_t                  state_r, state_s;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [LEN_WIDTH-1:0]    len_r;
  logic [1:0]              size_r;
  logic                    wrap_r;
  logic [LEN_WIDTH:0]      cnt_r;
  logic                    err_r;
  logic                    r_valid_r, r_last_r;
  logic [DATA_WIDTH-1:0]   r_data_r;
  logic                    last_s, rd_issue_s;

  // WRAP only applies to 2/4/8/16-beat bursts; any other length steps like INCR.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(
    input logic [ADDR_WIDTH-1:0] a,
    input logic [LEN_WIDTH-1:0]  len,
    input logic [1:0]            size,
    input logic                  wrap
  );
    logic [ADDR_WIDTH-1:0] step, incr, mask;
    step = ADDR_WIDTH'(1'b1) << size;
    incr = a + step;
    case (len)
      LEN_WIDTH'(1):  mask = (step << 3'd1) - ADDR_WIDTH'(1'b1);
      LEN_WIDTH'(3):  mask = (step << 3'd2) - ADDR_WIDTH'(1'b1);
      LEN_WIDTH'(7):  mask = (step << 3'd3) - ADDR_WIDTH'(1'b1);
      LEN_WIDTH'(15): mask = (step << 3'd4) - ADDR_WIDTH'(1'b1);
      default:        mask = '0;
    endcase
    if (wrap && (mask != '0)) begin
      return (a & ~mask) | (incr & mask);
    end else begin
      return incr;
    end
  endfunction

  assign last_s     = (cnt_r == (LEN_WIDTH+1)'(1'b1));
  assign rd_issue_s = (state_r == RD) && (cnt_r != '0) && (!r_valid_r || r_ready);

  assign r_valid = r_valid_r;
  assign r_last  = r_last_r;
  assign r_data  = r_data_r;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and handshake/RAM strobes
  always_comb begin
    state_s   = state_r;
    req_ready = 1'b0;
    w_ready   = 1'b0;
    b_valid   = 1'b0;
    b_err     = 1'b0;
    ram_en    = 1'b0;
    ram_re    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_size  = 2'd0;
    ram_wmask = '0;
    ram_wdata = '0;
    case (state_r)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_s = req_write ? WR : RD;
        end else begin
          state_s = IDLE;
        end
      end
      RD: begin
        if (rd_issue_s) begin
          ram_en   = 1'b1;
          ram_re   = 1'b1;
          ram_addr = addr_r;
          ram_size = size_r;
        end else begin
          ram_en = 1'b0;
        end
        if (r_valid_r && r_ready && r_last_r) begin
          state_s = IDLE;
        end else begin
          state_s = RD;
        end
      end
      WR: begin
        w_ready = 1'b1;
        if (w_valid) begin
          ram_en    = 1'b1;
          ram_we    = 1'b1;
          ram_addr  = addr_r;
          ram_size  = size_r;
          ram_wmask = w_strb;
          ram_wdata = w_data;
          state_s   = last_s ? BRESP : WR;
        end else begin
          state_s = WR;
        end
      end
      BRESP: begin
        b_valid = 1'b1;
        b_err   = err_r;
        if (b_ready) begin
          state_s = IDLE;
        end else begin
          state_s = BRESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Burst context, beat counter, error flag and registered read buffer
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_r    <= '0;
      len_r     <= '0;
      size_r    <= 2'd0;
      wrap_r    <= 1'b0;
      cnt_r     <= '0;
      err_r     <= 1'b0;
      r_valid_r <= 1'b0;
      r_last_r  <= 1'b0;
      r_data_r  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            addr_r <= req_addr;
            len_r  <= req_len;
            size_r <= req_size;
            wrap_r <= req_wrap;
            cnt_r  <= {1'b0, req_len} + (LEN_WIDTH+1)'(1'b1);
            err_r  <= 1'b0;
          end
        end
        RD: begin
          if (rd_issue_s) begin
            r_data_r  <= ram_rdata;
            r_valid_r <= 1'b1;
            r_last_r  <= last_s;
            cnt_r     <= cnt_r - (LEN_WIDTH+1)'(1'b1);
            addr_r    <= next_addr(addr_r, len_r, size_r, wrap_r);
          end else if (r_valid_r && r_ready) begin
            r_valid_r <= 1'b0;
            r_last_r  <= 1'b0;
            r_data_r  <= '0;
          end
        end
        WR: begin
          if (w_valid) begin
            // A misplaced w_last is flagged but the beat is still committed.
            if (w_last != last_s) begin
              err_r <= 1'b1;
            end
            cnt_r  <= cnt_r - (LEN_WIDTH+1)'(1'b1);
            addr_r <= next_addr(addr_r, len_r, size_r, wrap_r);
          end
        end
        BRESP: begin
          err_r <= err_r;
        end
        default: begin
          r_valid_r <= 1'b0;
          r_last_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dpic_burst_ctrl.sv
// Directed bench for dpic_burst_ctrl: a RAM model plus scoreboard queues of expected
// RAM accesses and read beats, popped and compared as the DUT produces them.
module tb_dpic_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_wrap;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic [1:0]  req_size;
  logic        w_valid, w_ready, w_last;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        r_valid, r_ready, r_last;
  logic [31:0] r_data;
  logic        b_valid, b_ready, b_err;
  logic        ram_en, ram_re, ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [1:0]  ram_size;
  logic [3:0]  ram_wmask;

  typedef struct { logic [31:0] d; logic l; } rbeat_t;
  typedef struct { logic [31:0] a; logic [3:0] m; logic [31:0] d; } wbeat_t;

  logic [31:0] exp_ra[$];
  rbeat_t      exp_r[$];
  wbeat_t      exp_w[$];

  int tests = 0;
  int fails = 0;
  int n_re  = 0;

  always #5 clk = ~clk;

  dpic_burst_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .req_size(req_size), .req_write(req_write), .req_wrap(req_wrap),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_last(r_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_err(b_err),
    .ram_en(ram_en), .ram_re(ram_re), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_size(ram_size), .ram_wmask(ram_wmask), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  assign ram_rdata = (ram_en && ram_re) ? model_rd(ram_addr) : 32'hBAD0_BAD0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every RAM access and every read transfer must match the next expectation.
  always @(negedge clk) begin
    if (ram_en && ram_re) begin
      n_re++;
      chk("rd_access_expected", 32'(exp_ra.size() != 0), 32'd1);
      if (exp_ra.size() != 0) chk("ram_raddr", ram_addr, exp_ra.pop_front());
    end
    if (ram_en && ram_we) begin
      chk("wr_access_expected", 32'(exp_w.size() != 0), 32'd1);
      if (exp_w.size() != 0) begin
        wbeat_t e;
        e = exp_w.pop_front();
        chk("ram_waddr", ram_addr, e.a);
        chk("ram_wmask", 32'(ram_wmask), 32'(e.m));
        chk("ram_wdata", ram_wdata, e.d);
      end
    end
    if (r_valid && r_ready) begin
      chk("r_beat_expected", 32'(exp_r.size() != 0), 32'd1);
      if (exp_r.size() != 0) begin
        rbeat_t e;
        e = exp_r.pop_front();
        chk("r_data", r_data, e.d);
        chk("r_last", 32'(r_last), 32'(e.l));
      end
    end
  end

  task automatic push_rd(input logic [31:0] a, input logic l);
    rbeat_t e;
    e.d = model_rd(a);
    e.l = l;
    exp_ra.push_back(a);
    exp_r.push_back(e);
  endtask

  task automatic push_w(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    wbeat_t e;
    e.a = a; e.m = m; e.d = d;
    exp_w.push_back(e);
  endtask

  task automatic send_req(input logic [31:0] a, input logic [7:0] len, input logic [1:0] sz,
                          input logic wr, input logic wrap);
    req_valid = 1'b1; req_addr = a; req_len = len; req_size = sz; req_write = wr; req_wrap = wrap;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    chk("req_accept", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain_rd();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (exp_r.size() == 0) break;
    end
    chk("rd_drain", 32'(exp_r.size()), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rd_back_idle", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] m, input logic l);
    w_valid = 1'b1; w_data = d; w_strb = m; w_last = l;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (w_ready) break;
    end
    chk("w_accept", 32'(w_ready), 32'd1);
    @(posedge clk); #1;
    w_valid = 1'b0; w_last = 1'b0;
  endtask

  task automatic bresp(input logic exp_err);
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("b_valid_hold", 32'(b_valid), 32'd1);
      chk("b_err", 32'(b_err), 32'(exp_err));
      chk("w_ready_bresp", 32'(w_ready), 32'd0);
      @(posedge clk); #1;
    end
    b_ready = 1'b1;
    @(posedge clk); #1;
    b_ready = 1'b0;
    @(negedge clk);
    chk("b_valid_clear", 32'(b_valid), 32'd0);
    chk("wr_back_idle", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0; req_size = '0;
    req_write = 1'b0; req_wrap = 1'b0; w_valid = 1'b0; w_data = '0; w_strb = '0;
    w_last = 1'b0; r_ready = 1'b0; b_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_r_valid", 32'(r_valid), 32'd0);
    chk("rst_r_last", 32'(r_last), 32'd0);
    chk("rst_r_data", r_data, 32'd0);
    chk("rst_b_valid", 32'(b_valid), 32'd0);
    chk("rst_b_err", 32'(b_err), 32'd0);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_w_ready", 32'(w_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Read INCR, full throughput: issue on cycles 0..3, r_valid on cycles 1..4
    r_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_rd(32'h100 + 32'(4 * i), i == 3);
    send_req(32'h100, 8'd3, 2'd2, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("incr_ram_re", 32'(ram_re), 32'(k < 4));
      chk("incr_r_valid", 32'(r_valid), 32'(k >= 1));
      chk("incr_r_last", 32'(r_last), 32'(k == 4));
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("incr_idle", 32'(req_ready), 32'd1);
    @(posedge clk); #1;

    // Read backpressure: stalled beat held, no RAM access, exactly 4 reads
    n_re = 0;
    r_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_rd(32'h100 + 32'(4 * i), i == 3);
    send_req(32'h100, 8'd3, 2'd2, 1'b0, 1'b0);
    @(posedge clk); #1;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("bp_r_valid", 32'(r_valid), 32'd1);
      chk("bp_r_data_held", r_data, model_rd(32'h100));
      chk("bp_no_ram", 32'(ram_en), 32'd0);
      @(posedge clk); #1;
    end
    r_ready = 1'b1;
    drain_rd();
    chk("bp_re_count", 32'(n_re), 32'd4);

    // Read WRAP, 4 beats of 4 bytes wrapping inside a 16-byte block
    push_rd(32'h1C, 1'b0); push_rd(32'h10, 1'b0); push_rd(32'h14, 1'b0); push_rd(32'h18, 1'b1);
    send_req(32'h1C, 8'd3, 2'd2, 1'b0, 1'b1);
    drain_rd();

    // WRAP with 3 beats behaves as INCR
    push_rd(32'h1C, 1'b0); push_rd(32'h20, 1'b0); push_rd(32'h24, 1'b1);
    send_req(32'h1C, 8'd2, 2'd2, 1'b0, 1'b1);
    drain_rd();

    // Byte-size WRAP of 2 beats
    push_rd(32'h23, 1'b0); push_rd(32'h22, 1'b1);
    send_req(32'h23, 8'd1, 2'd0, 1'b0, 1'b1);
    drain_rd();

    // INCR across the top of the address space
    push_rd(32'hFFFF_FFF8, 1'b0); push_rd(32'hFFFF_FFFC, 1'b0);
    push_rd(32'h0000_0000, 1'b0); push_rd(32'h0000_0004, 1'b1);
    send_req(32'hFFFF_FFF8, 8'd3, 2'd2, 1'b0, 1'b0);
    drain_rd();

    // Single-beat read
    push_rd(32'h40, 1'b1);
    send_req(32'h40, 8'd0, 2'd2, 1'b0, 1'b0);
    drain_rd();

    // Write, correct w_last
    push_w(32'h200, 4'hF, 32'hCAFE_0001);
    push_w(32'h204, 4'h3, 32'hCAFE_0002);
    send_req(32'h200, 8'd1, 2'd2, 1'b1, 1'b0);
    w_beat(32'hCAFE_0001, 4'hF, 1'b0);
    w_beat(32'hCAFE_0002, 4'h3, 1'b1);
    bresp(1'b0);

    // Write with early w_last: all beats still written, error reported, extra beat refused
    push_w(32'h300, 4'h1, 32'h1111_0000);
    push_w(32'h304, 4'h2, 32'h2222_0000);
    push_w(32'h308, 4'h4, 32'h3333_0000);
    send_req(32'h300, 8'd2, 2'd2, 1'b1, 1'b0);
    w_beat(32'h1111_0000, 4'h1, 1'b1);
    w_beat(32'h2222_0000, 4'h2, 1'b0);
    w_beat(32'h3333_0000, 4'h4, 1'b0);
    w_valid = 1'b1; w_data = 32'h4444_0000; w_strb = 4'hF;
    @(negedge clk);
    chk("extra_w_ready", 32'(w_ready), 32'd0);
    chk("extra_ram_en", 32'(ram_en), 32'd0);
    @(posedge clk); #1;
    w_valid = 1'b0;
    bresp(1'b1);

    // Reset in the middle of an 8-beat read
    r_ready = 1'b1;
    push_rd(32'h400, 1'b0);
    exp_ra.push_back(32'h404);
    send_req(32'h400, 8'd7, 2'd2, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_r_valid", 32'(r_valid), 32'd0);
    chk("mid_rst_r_data", r_data, 32'd0);
    chk("mid_rst_ram_en", 32'(ram_en), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("post_rst_req_ready", 32'(req_ready), 32'd1);
      chk("post_rst_ram_en", 32'(ram_en), 32'd0);
      chk("post_rst_r_valid", 32'(r_valid), 32'd0);
      @(posedge clk); #1;
    end

    chk("left_rd_addr", 32'(exp_ra.size()), 32'd0);
    chk("left_rd_beats", 32'(exp_r.size()), 32'd0);
    chk("left_wr_beats", 32'(exp_w.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
